// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-map constants for the direct-mapped data cache
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT_RAM,
        ST_FILL
    } cache_state_t;

    // Default address map: [1:0] byte, [4:2] word-in-line, [5] line index, [31:6] tag
    localparam int BYTE_OFFSET_LSB      = 0;
    localparam int BYTE_OFFSET_BITWIDTH = 2;
    localparam int WORD_IX_LSB          = 2;
    localparam int WORD_IX_BITWIDTH     = 3;
    localparam int LINE_IX_LSB          = 5;
    localparam int LINE_IX_WIDTH        = 1;
    localparam int TAG_LSB              = 6;
    localparam int TAG_BITWIDTH         = 26;

    localparam logic RAM_CMD_READ  = 1'b0;
    localparam logic RAM_CMD_WRITE = 1'b1;

endpackage

// File: rtl/cache_line_ram.sv
// rtl/cache_line_ram.sv - per-line word storage with byte-enable word write and whole-beat write
module cache_line_ram #(
    parameter int LINE_IX_BITWIDTH         = 1,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int DATA_BITWIDTH            = 32,
    parameter int BEAT_IX_BITWIDTH         = 2,
    parameter int BEAT_BITWIDTH            = 64
) (
    input  logic                                clk,
    input  logic [LINE_IX_BITWIDTH-1:0]         line_ix,
    input  logic [DATA_IX_IN_LINE_BITWIDTH-1:0] word_ix,
    output logic [DATA_BITWIDTH-1:0]            rd_data,
    input  logic                                wr_en,
    input  logic [DATA_BITWIDTH/8-1:0]          wr_be,
    input  logic [DATA_BITWIDTH-1:0]            wr_data,
    input  logic                                beat_en,
    input  logic [BEAT_IX_BITWIDTH-1:0]         beat_ix,
    input  logic [BEAT_BITWIDTH-1:0]            beat_data
);

    localparam int DEPTH          = 1 << (LINE_IX_BITWIDTH + DATA_IX_IN_LINE_BITWIDTH);
    localparam int WORDS_PER_BEAT = BEAT_BITWIDTH / DATA_BITWIDTH;
    localparam int WIB_BITWIDTH   = DATA_IX_IN_LINE_BITWIDTH - BEAT_IX_BITWIDTH;

    logic [DATA_BITWIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[{line_ix, word_ix}];

    // Core writes merge selected bytes; a burst beat overwrites its consecutive words
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_BITWIDTH / 8; b++) begin
                if (wr_be[b]) begin
                    mem[{line_ix, word_ix}][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (beat_en) begin
            for (int w = 0; w < WORDS_PER_BEAT; w++) begin
                mem[{line_ix, beat_ix, WIB_BITWIDTH'(w)}] <= beat_data[w*DATA_BITWIDTH +: DATA_BITWIDTH];
            end
        end
    end

endmodule

// File: rtl/cache_data.sv
// rtl/cache_data.sv - direct-mapped read/write data cache over a burst-read RAM; CACHE_STATS_EN adds hit/miss counters
module cache_data
    import cache_pkg::*;
#(
    parameter int LINE_IX_BITWIDTH         = 1,
    parameter int ADDRESS_BITWIDTH         = 32,
    parameter int DATA_BITWIDTH            = 32,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_DEPTH_BITWIDTH       = 4,
    parameter int RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int RAM_BURST_DATA_COUNT     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [ADDRESS_BITWIDTH-1:0]        address,
    output logic [DATA_BITWIDTH-1:0]           data_out,
    output logic                               data_out_ready,
    input  logic [DATA_BITWIDTH-1:0]           data_in,
    input  logic [DATA_BITWIDTH/8-1:0]         write_enable_bytes,
    output logic                               busy,
    output logic                               br_cmd,
    output logic                               br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
    input  logic                               br_rd_data_valid,
    input  logic                               br_busy
);

    localparam int WORD_FIELD_LSB = BYTE_OFFSET_BITWIDTH;
    localparam int LINE_FIELD_LSB = WORD_FIELD_LSB + DATA_IX_IN_LINE_BITWIDTH;
    localparam int TAG_FIELD_LSB  = LINE_FIELD_LSB + LINE_IX_BITWIDTH;
    localparam int TAG_W          = ADDRESS_BITWIDTH - TAG_FIELD_LSB;
    localparam int NUM_LINES      = 1 << LINE_IX_BITWIDTH;
    localparam int BE_W           = DATA_BITWIDTH / 8;
    localparam int WORDS_PER_BEAT = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int WIB_W          = $clog2(WORDS_PER_BEAT);
    localparam int BEAT_W         = $clog2(RAM_BURST_DATA_COUNT);
    localparam int RAM_BYTE_W     = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
    localparam logic [RAM_DEPTH_BITWIDTH-1:0] BURST_MASK = RAM_DEPTH_BITWIDTH'(RAM_BURST_DATA_COUNT - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RAM_BURST_DATA_COUNT - 1);

    cache_state_t state, state_next;

    logic [ADDRESS_BITWIDTH-1:0] req_addr;
    logic [DATA_BITWIDTH-1:0]    req_data;
    logic [BE_W-1:0]             req_be;
    logic [TAG_W-1:0]            tag_arr [NUM_LINES];
    logic [NUM_LINES-1:0]        valid_arr;
    logic [BEAT_W-1:0]           beat_cnt;

    logic [DATA_IX_IN_LINE_BITWIDTH-1:0] req_word_ix;
    logic [LINE_IX_BITWIDTH-1:0]         req_line;
    logic [TAG_W-1:0]                    req_tag;
    logic [BEAT_W-1:0]                   req_beat;
    logic [WIB_W-1:0]                    req_half;
    logic                                hit;
    logic                                is_write;
    logic                                crit_beat;
    logic [DATA_BITWIDTH-1:0]            stored_word;
    logic [DATA_BITWIDTH-1:0]            hit_word;
    logic [DATA_BITWIDTH-1:0]            beat_word;
    logic [DATA_BITWIDTH-1:0]            critical_word;
    logic [RAM_BURST_DATA_BITWIDTH-1:0]  fill_beat_data;
    logic                                unused_addr_bits;

    function automatic logic [DATA_BITWIDTH-1:0] merge_bytes(
        input logic [DATA_BITWIDTH-1:0] old_word,
        input logic [DATA_BITWIDTH-1:0] new_word,
        input logic [BE_W-1:0]          be
    );
        merge_bytes = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) merge_bytes[b*8 +: 8] = new_word[b*8 +: 8];
        end
    endfunction

    assign req_word_ix      = req_addr[LINE_FIELD_LSB-1:WORD_FIELD_LSB];
    assign req_line         = req_addr[TAG_FIELD_LSB-1:LINE_FIELD_LSB];
    assign req_tag          = req_addr[ADDRESS_BITWIDTH-1:TAG_FIELD_LSB];
    assign req_beat         = req_word_ix[DATA_IX_IN_LINE_BITWIDTH-1:WIB_W];
    assign req_half         = req_word_ix[WIB_W-1:0];
    assign hit              = valid_arr[req_line] && (tag_arr[req_line] == req_tag);
    assign is_write         = |req_be;
    assign crit_beat        = (beat_cnt == req_beat);
    assign br_cmd           = RAM_CMD_READ;
    assign unused_addr_bits = ^req_addr[WORD_FIELD_LSB-1:0];

    // Requested word as seen by the core: stored copy on a hit, arriving beat during a fill,
    // with any pending write merged in so storage and data_out agree
    always_comb begin
        hit_word       = is_write ? merge_bytes(stored_word, req_data, req_be) : stored_word;
        beat_word      = br_rd_data[int'(req_half)*DATA_BITWIDTH +: DATA_BITWIDTH];
        critical_word  = is_write ? merge_bytes(beat_word, req_data, req_be) : beat_word;
        fill_beat_data = br_rd_data;
        if (is_write && crit_beat) begin
            fill_beat_data[int'(req_half)*DATA_BITWIDTH +: DATA_BITWIDTH] = critical_word;
        end
    end

    cache_line_ram #(
        .LINE_IX_BITWIDTH        (LINE_IX_BITWIDTH),
        .DATA_IX_IN_LINE_BITWIDTH(DATA_IX_IN_LINE_BITWIDTH),
        .DATA_BITWIDTH           (DATA_BITWIDTH),
        .BEAT_IX_BITWIDTH        (BEAT_W),
        .BEAT_BITWIDTH           (RAM_BURST_DATA_BITWIDTH)
    ) u_line_ram (
        .clk      (clk),
        .line_ix  (req_line),
        .word_ix  (req_word_ix),
        .rd_data  (stored_word),
        .wr_en    ((state == ST_LOOKUP) && hit && is_write),
        .wr_be    (req_be),
        .wr_data  (req_data),
        .beat_en  ((state == ST_FILL) && br_rd_data_valid),
        .beat_ix  (beat_cnt),
        .beat_data(fill_beat_data)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state: one lookup per request, a miss waits for the RAM and then streams the line in
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (enable) state_next = ST_LOOKUP;
            ST_LOOKUP:   state_next = hit ? ST_IDLE : ST_WAIT_RAM;
            ST_WAIT_RAM: if (!br_busy) state_next = ST_FILL;
            ST_FILL:     if (br_rd_data_valid && (beat_cnt == LAST_BEAT)) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Request capture, response, RAM command and fill bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr       <= '0;
            req_data       <= '0;
            req_be         <= '0;
            valid_arr      <= '0;
            beat_cnt       <= '0;
            data_out       <= '0;
            data_out_ready <= 1'b0;
            busy           <= 1'b0;
            br_cmd_en      <= 1'b0;
            br_addr        <= '0;
        end else begin
            br_cmd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        req_addr       <= address;
                        req_data       <= data_in;
                        req_be         <= write_enable_bytes;
                        data_out_ready <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        data_out       <= hit_word;
                        data_out_ready <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        valid_arr[req_line] <= 1'b0;
                        beat_cnt            <= '0;
                    end
                end
                ST_WAIT_RAM: begin
                    if (!br_busy) begin
                        br_cmd_en <= 1'b1;
                        br_addr   <= req_addr[RAM_BYTE_W +: RAM_DEPTH_BITWIDTH] & ~BURST_MASK;
                    end
                end
                ST_FILL: begin
                    if (br_rd_data_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (crit_beat) begin
                            data_out       <= critical_word;
                            data_out_ready <= 1'b1;
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            valid_arr[req_line] <= 1'b1;
                            busy                <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag is claimed at miss time; the line stays invalid until the last beat lands
    always_ff @(posedge clk) begin
        if ((state == ST_LOOKUP) && !hit) tag_arr[req_line] <= req_tag;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] stat_cache_hits;
    logic [31:0] stat_cache_misses;
    logic        unused_stats;

    // One count per lookup, split by outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cache_hits   <= '0;
            stat_cache_misses <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit) stat_cache_hits   <= stat_cache_hits + 32'd1;
            else     stat_cache_misses <= stat_cache_misses + 32'd1;
        end
    end

    assign unused_stats = ^{stat_cache_hits, stat_cache_misses};
`else
`endif

endmodule

// File: tb/tb_cache_data.sv
// tb/tb_cache_data.sv - directed self-checking bench for cache_data with a BurstRAM model
module tb_cache_data;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] address;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic [31:0] data_in;
    logic [3:0]  write_enable_bytes;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] img [32];
    logic [63:0] ram_mem [16];
    logic        ram_active;
    int          ram_cyc;
    int          ram_base;
    int          cmd_count = 0;
    logic [3:0]  last_addr = 4'h0;

    always #5 clk = ~clk;

    cache_data dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .address           (address),
        .data_out          (data_out),
        .data_out_ready    (data_out_ready),
        .data_in           (data_in),
        .write_enable_bytes(write_enable_bytes),
        .busy              (busy),
        .br_cmd            (br_cmd),
        .br_cmd_en         (br_cmd_en),
        .br_addr           (br_addr),
        .br_rd_data        (br_rd_data),
        .br_rd_data_valid  (br_rd_data_valid),
        .br_busy           (br_busy)
    );

    // BurstRAM model: beats start 3 cycles after cmd_en, busy until the last beat
    initial begin
        for (int i = 0; i < 32; i++) img[i] = 32'h0;
        img[0] = 32'hB7C6A980; img[1] = 32'h3F5A2E14; img[2] = 32'hAB4C3E6F;
        img[4] = 32'hD5B8A9C4; img[8] = 32'h2F5E3C7A; img[17] = 32'h0A1B2C3D;
        for (int i = 0; i < 16; i++) ram_mem[i] = {img[2*i+1], img[2*i]};
        br_busy = 1'b0; br_rd_data_valid = 1'b0; br_rd_data = 64'h0;
        ram_active = 1'b0; ram_cyc = 0; ram_base = 0;
        forever begin
            @(posedge clk); #1;
            if (ram_active) begin
                ram_cyc++;
                if (ram_cyc >= 3 && ram_cyc <= 6) begin
                    br_rd_data_valid = 1'b1;
                    br_rd_data = ram_mem[(ram_base + ram_cyc - 3) % 16];
                end else if (ram_cyc == 7) begin
                    br_rd_data_valid = 1'b0;
                    br_rd_data = 64'h0;
                    br_busy = 1'b0;
                    ram_active = 1'b0;
                end
            end else if (br_cmd_en === 1'b1) begin
                ram_active = 1'b1;
                ram_cyc = 0;
                ram_base = int'(br_addr);
                br_busy = 1'b1;
                cmd_count++;
                last_addr = br_addr;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         output int lat, output logic [31:0] dout);
        @(posedge clk); #1;
        address = a; data_in = d; write_enable_bytes = be; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        lat = 1;
        while (data_out_ready !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        dout = data_out;
    endtask

    task automatic wait_not_busy(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0); end
        checks++; if (data_out_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", data_out_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (br_cmd_en !== 1'b0) begin errors++; $display("FAIL reset_cmd_en: got %b expected 0", br_cmd_en); end
        checks++; if (br_cmd !== 1'b0) begin errors++; $display("FAIL reset_cmd: got %b expected 0", br_cmd); end
        checks++; if (br_addr !== 4'h0) begin errors++; $display("FAIL reset_br_addr: got %h expected 0", br_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_read_miss;
        int lat; int n; int c0; logic [31:0] dout;
        c0 = cmd_count;
        issue(32'd0, 32'h0, 4'h0, lat, dout);
        checks++; if (dout !== 32'hB7C6A980) begin errors++; $display("FAIL miss0_data: got %h expected B7C6A980", dout); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL miss0_latency: got %0d expected 7", lat); end
        checks++; if (cmd_count !== c0 + 1) begin errors++; $display("FAIL miss0_cmds: got %0d expected %0d", cmd_count, c0 + 1); end
        checks++; if (last_addr !== 4'd0) begin errors++; $display("FAIL miss0_br_addr: got %0d expected 0", last_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL miss0_busy_at_ready: got %b expected 1", busy); end
        wait_not_busy(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL miss0_busy_drop: got %0d cycles expected 3", n); end
`ifdef CACHE_STATS_EN
        checks++; if (dut.stat_cache_misses !== 32'd1) begin errors++; $display("FAIL miss0_stat_misses: got %0d expected 1", dut.stat_cache_misses); end
`endif
    endtask

    task automatic test_read_hits;
        logic [31:0] addrs [3];
        logic [31:0] exp [3];
        int lat; int c0; logic [31:0] dout;
        addrs[0] = 32'd4;  exp[0] = 32'h3F5A2E14;
        addrs[1] = 32'd8;  exp[1] = 32'hAB4C3E6F;
        addrs[2] = 32'd16; exp[2] = 32'hD5B8A9C4;
        c0 = cmd_count;
        for (int i = 0; i < 3; i++) begin
            issue(addrs[i], 32'h0, 4'h0, lat, dout);
            checks++; if (dout !== exp[i]) begin errors++; $display("FAIL hit_data[%0d]: got %h expected %h", addrs[i], dout, exp[i]); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency[%0d]: got %0d expected 2", addrs[i], lat); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hit_busy[%0d]: got %b expected 0", addrs[i], busy); end
`ifdef CACHE_STATS_EN
            checks++; if (dut.stat_cache_hits !== 32'(i + 1)) begin errors++; $display("FAIL hit_stat_hits: got %0d expected %0d", dut.stat_cache_hits, i + 1); end
`endif
        end
        checks++; if (cmd_count !== c0) begin errors++; $display("FAIL hit_no_ram_cmd: got %0d expected %0d", cmd_count, c0); end
    endtask

    task automatic test_write_hit;
        int lat; int c0; logic [31:0] dout;
        c0 = cmd_count;
        issue(32'd4, 32'h0000BEEF, 4'b0011, lat, dout);
        checks++; if (dout !== 32'h3F5ABEEF) begin errors++; $display("FAIL write_hit_data: got %h expected 3F5ABEEF", dout); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_hit_latency: got %0d expected 2", lat); end
        issue(32'd4, 32'h0, 4'h0, lat, dout);
        checks++; if (dout !== 32'h3F5ABEEF) begin errors++; $display("FAIL write_readback_data: got %h expected 3F5ABEEF", dout); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_readback_latency: got %0d expected 2", lat); end
        checks++; if (cmd_count !== c0) begin errors++; $display("FAIL write_no_miss: got %0d expected %0d", cmd_count, c0); end
    endtask

    task automatic test_miss_line1;
        int lat; int n; int c0; logic [31:0] dout;
        c0 = cmd_count;
        issue(32'd32, 32'h0, 4'h0, lat, dout);
        checks++; if (dout !== 32'h2F5E3C7A) begin errors++; $display("FAIL line1_data: got %h expected 2F5E3C7A", dout); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL line1_latency: got %0d expected 7", lat); end
        checks++; if (last_addr !== 4'd4) begin errors++; $display("FAIL line1_br_addr: got %0d expected 4", last_addr); end
        checks++; if (cmd_count !== c0 + 1) begin errors++; $display("FAIL line1_cmds: got %0d expected %0d", cmd_count, c0 + 1); end
        wait_not_busy(n);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL line1_busy_timeout: got %b expected 0", busy); end
        issue(32'd0, 32'h0, 4'h0, lat, dout);
        checks++; if (dout !== 32'hB7C6A980) begin errors++; $display("FAIL line0_kept_data: got %h expected B7C6A980", dout); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL line0_kept_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_evict;
        int lat; int n; int c0; logic [31:0] dout;
        c0 = cmd_count;
        issue(32'd68, 32'h0, 4'h0, lat, dout);
        checks++; if (dout !== 32'h0A1B2C3D) begin errors++; $display("FAIL evict_data: got %h expected 0A1B2C3D", dout); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL evict_latency: got %0d expected 7", lat); end
        checks++; if (last_addr !== 4'd8) begin errors++; $display("FAIL evict_br_addr: got %0d expected 8", last_addr); end
        checks++; if (cmd_count !== c0 + 1) begin errors++; $display("FAIL evict_cmds: got %0d expected %0d", cmd_count, c0 + 1); end
        wait_not_busy(n);
        issue(32'd4, 32'h0, 4'h0, lat, dout);
        checks++; if (dout !== 32'h3F5A2E14) begin errors++; $display("FAIL evict_dirty_dropped: got %h expected 3F5A2E14", dout); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL evict_refetch_latency: got %0d expected 7", lat); end
        checks++; if (last_addr !== 4'd0) begin errors++; $display("FAIL evict_refetch_br_addr: got %0d expected 0", last_addr); end
        wait_not_busy(n);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL evict_busy_timeout: got %b expected 0", busy); end
    endtask

    task automatic test_enable_during_fill;
        int lat; int n; int c0; logic [31:0] dout;
        c0 = cmd_count;
        issue(32'd68, 32'h0, 4'h0, lat, dout);
        checks++; if (dout !== 32'h0A1B2C3D) begin errors++; $display("FAIL fill_pulse_data: got %h expected 0A1B2C3D", dout); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_pulse_busy: got %b expected 1", busy); end
        address = 32'd0; data_in = 32'h0; write_enable_bytes = 4'h0; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        checks++; if (data_out_ready !== 1'b1) begin errors++; $display("FAIL fill_pulse_ready_kept: got %b expected 1", data_out_ready); end
        wait_not_busy(n);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_out_ready !== 1'b1) begin errors++; $display("FAIL fill_pulse_ready_after: got %b expected 1", data_out_ready); end
        checks++; if (data_out !== 32'h0A1B2C3D) begin errors++; $display("FAIL fill_pulse_data_after: got %h expected 0A1B2C3D", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_pulse_idle: got %b expected 0", busy); end
        checks++; if (cmd_count !== c0 + 1) begin errors++; $display("FAIL fill_pulse_cmds: got %0d expected %0d", cmd_count, c0 + 1); end
        issue(32'd68, 32'h0, 4'h0, lat, dout);
        checks++; if (lat !== 2) begin errors++; $display("FAIL fill_pulse_line_valid: got %0d expected 2", lat); end
    endtask

    task automatic test_write_miss;
        int lat; int n; logic [31:0] dout;
        issue(32'd16, 32'hCAFE0000, 4'b1100, lat, dout);
        checks++; if (dout !== 32'hCAFEA9C4) begin errors++; $display("FAIL wmiss_data: got %h expected CAFEA9C4", dout); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL wmiss_critical_latency: got %0d expected 9", lat); end
        checks++; if (last_addr !== 4'd0) begin errors++; $display("FAIL wmiss_br_addr: got %0d expected 0", last_addr); end
        wait_not_busy(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL wmiss_busy_drop: got %0d cycles expected 1", n); end
        issue(32'd16, 32'h0, 4'h0, lat, dout);
        checks++; if (dout !== 32'hCAFEA9C4) begin errors++; $display("FAIL wmiss_readback: got %h expected CAFEA9C4", dout); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL wmiss_readback_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_reset_mid_fill;
        int lat; int n; int c0; logic [31:0] dout;
        issue(32'd68, 32'h0, 4'h0, lat, dout);
        checks++; if (lat !== 7) begin errors++; $display("FAIL rstfill_first_latency: got %0d expected 7", lat); end
        rst = 1'b1;
        #1;
        checks++; if (data_out_ready !== 1'b0) begin errors++; $display("FAIL rstfill_ready: got %b expected 0", data_out_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstfill_busy: got %b expected 0", busy); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rstfill_data_out: got %h expected 0", data_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (br_busy !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (br_busy !== 1'b0) begin errors++; $display("FAIL rstfill_ram_idle: got %b expected 0", br_busy); end
        @(posedge clk); #1;
        checks++; if (data_out_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstfill_stray_beats: got ready=%b busy=%b expected 0 0", data_out_ready, busy); end
        c0 = cmd_count;
        issue(32'd68, 32'h0, 4'h0, lat, dout);
        checks++; if (cmd_count !== c0 + 1) begin errors++; $display("FAIL rstfill_remiss: got %0d expected %0d", cmd_count, c0 + 1); end
        checks++; if (dout !== 32'h0A1B2C3D) begin errors++; $display("FAIL rstfill_data: got %h expected 0A1B2C3D", dout); end
        wait_not_busy(n);
        issue(32'd32, 32'h0, 4'h0, lat, dout);
        checks++; if (cmd_count !== c0 + 2) begin errors++; $display("FAIL rstfill_line1_invalid: got %0d expected %0d", cmd_count, c0 + 2); end
        checks++; if (dout !== 32'h2F5E3C7A) begin errors++; $display("FAIL rstfill_line1_data: got %h expected 2F5E3C7A", dout); end
        wait_not_busy(n);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstfill_final_busy: got %b expected 0", busy); end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; address = 32'h0; data_in = 32'h0; write_enable_bytes = 4'h0;
        test_reset;
        test_read_miss;
        test_read_hits;
        test_write_hit;
        test_miss_line1;
        test_evict;
        test_enable_during_fill;
        test_write_miss;
        test_reset_mid_fill;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
